// File: rtl/dsp48a1_result_monitor.sv
// dsp48a1_result_monitor: golden-model response checker for a DSP48A1 slice.
// Optional: define DSP_MON_CARRYOUT_CHK_EN to also compare CARRYOUT.
module dsp48a1_result_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             STOP,
   input  logic             VALID,
   input  logic [17:0]      A,
   input  logic [17:0]      B,
   input  logic [17:0]      D,
   input  logic [47:0]      C,
   input  logic [47:0]      PCIN,
   input  logic [7:0]       OPMODE,
   input  logic [47:0]      P_DUT,
   input  logic             CARRYOUT_DUT,
   output logic             MISMATCH,
   output logic             ERR_STICKY,
   output logic [CNT_W-1:0] CHECK_COUNT,
   output logic [CNT_W-1:0] ERR_COUNT,
   output logic [47:0]      FIRST_EXP,
   output logic [47:0]      FIRST_GOT,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t st, nxt;
   logic [1:0] dcnt;
   logic arm, ld1, cmp, fail;

   logic [17:0] a1, b1, d1;
   logic [47:0] c1, pc1;
   logic [7:0]  op1;
   logic        v1;

   logic [35:0] m2;
   logic [47:0] c2, pc2;
   logic [7:0]  op2;
   logic        v2;

   logic [47:0] pm;
   logic        v3;

   logic [17:0] pre, bsel;
   logic [35:0] prod;
   logic [47:0] xm, zm;
   logic [48:0] sum;
   logic        unused_bits;

   // state register; dcnt counts the cycles spent in DRAIN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st   <= S_IDLE;
         dcnt <= 2'd0;
      end else begin
         st   <= nxt;
         dcnt <= (st == S_DRAIN) ? dcnt + 2'd1 : 2'd0;
      end
   end

   // next state; STOP wins over START in RUN
   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  if (START) nxt = S_RUN;
         S_RUN:   if (STOP) nxt = S_DRAIN;
         S_DRAIN: if (dcnt == 2'd2) nxt = S_DONE;
         S_DONE:  if (START) nxt = S_RUN;
         default: nxt = S_IDLE;
      endcase
   end

   assign arm  = (nxt == S_RUN) && (st != S_RUN);
   assign ld1  = (st == S_RUN) && VALID;
   assign cmp  = v3 && ((st == S_RUN) || (st == S_DRAIN));
   assign BUSY = (st == S_RUN) || (st == S_DRAIN);
   assign DONE = (st == S_DONE);

   // S1: operand capture (A1/B1/C/D/OPMODE registers)
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a1  <= '0;
         b1  <= '0;
         d1  <= '0;
         c1  <= '0;
         pc1 <= '0;
         op1 <= '0;
         v1  <= 1'b0;
      end else begin
         v1 <= ld1 && !arm;
         if (ld1) begin
            a1  <= A;
            b1  <= B;
            d1  <= D;
            c1  <= C;
            pc1 <= PCIN;
            op1 <= OPMODE;
         end
      end
   end

   // pre-adder and unsigned multiplier
   always_comb begin
      pre  = op1[6] ? d1 - b1 : d1 + b1;
      bsel = op1[4] ? pre : b1;
      prod = {18'd0, a1} * {18'd0, bsel};
   end

   // S2: M register plus the operands the post-adder still needs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m2  <= '0;
         c2  <= '0;
         pc2 <= '0;
         op2 <= '0;
         v2  <= 1'b0;
      end else begin
         v2 <= v1 && !arm;
         if (v1) begin
            m2  <= prod;
            c2  <= c1;
            pc2 <= pc1;
            op2 <= op1;
         end
      end
   end

   // X/Z multiplexers and the 49-bit post-adder
   always_comb begin
      xm = '0;
      zm = '0;
      case (op2[1:0])
         2'd0:    xm = '0;
         2'd1:    xm = {12'd0, m2};
         2'd2:    xm = pm;
         default: xm = {d1[11:0], a1, b1};
      endcase
      case (op2[3:2])
         2'd0:    zm = '0;
         2'd1:    zm = pc2;
         2'd2:    zm = pm;
         default: zm = c2;
      endcase
      if (op2[7])
         sum = {1'b0, zm} - ({1'b0, xm} + {48'd0, op2[5]});
      else
         sum = {1'b0, zm} + {1'b0, xm} + {48'd0, op2[5]};
   end

`ifdef DSP_MON_CARRYOUT_CHK_EN
   logic com;

   // S3: model P and CARRYOUT
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pm  <= '0;
         com <= 1'b0;
         v3  <= 1'b0;
      end else begin
         v3 <= v2 && !arm;
         if (v2) begin
            pm  <= sum[47:0];
            com <= sum[48];
         end
      end
   end

   assign fail = (pm != P_DUT) || (com != CARRYOUT_DUT);
   assign unused_bits = ^{op2[6], op2[4]};
`else
   // S3: model P register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pm <= '0;
         v3 <= 1'b0;
      end else begin
         v3 <= v2 && !arm;
         if (v2) pm <= sum[47:0];
      end
   end

   assign fail = (pm != P_DUT);
   assign unused_bits = ^{op2[6], op2[4], sum[48], CARRYOUT_DUT};
`endif

   // compare result and run statistics
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         MISMATCH    <= 1'b0;
         ERR_STICKY  <= 1'b0;
         CHECK_COUNT <= '0;
         ERR_COUNT   <= '0;
         FIRST_EXP   <= '0;
         FIRST_GOT   <= '0;
      end else begin
         MISMATCH <= cmp && fail;
         if (arm) begin
            ERR_STICKY  <= 1'b0;
            CHECK_COUNT <= '0;
            ERR_COUNT   <= '0;
            FIRST_EXP   <= '0;
            FIRST_GOT   <= '0;
         end else if (cmp) begin
            if (CHECK_COUNT != '1)
               CHECK_COUNT <= CHECK_COUNT + CNT_W'(1);
            if (fail) begin
               ERR_STICKY <= 1'b1;
               if (ERR_COUNT != '1)
                  ERR_COUNT <= ERR_COUNT + CNT_W'(1);
               if (!ERR_STICKY) begin
                  FIRST_EXP <= pm;
                  FIRST_GOT <= P_DUT;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dsp48a1_result_monitor.sv
// tb_dsp48a1_result_monitor: directed bench with a transaction-level model.
// The bench also plays the DSP, driving P_DUT/CARRYOUT_DUT with optional corruption.
module tb_dsp48a1_result_monitor;

   localparam int CW = 4;
   localparam logic [CW-1:0] CMAX = '1;
`ifdef DSP_MON_CARRYOUT_CHK_EN
   localparam int COE = 1;
`else
   localparam int COE = 0;
`endif
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic START = 1'b0;
   logic STOP = 1'b0;
   logic VALID = 1'b0;
   logic [17:0] A = '0;
   logic [17:0] B = '0;
   logic [17:0] D = '0;
   logic [47:0] C = '0;
   logic [47:0] PCIN = '0;
   logic [7:0]  OPMODE = '0;
   logic [47:0] P_DUT = '0;
   logic CARRYOUT_DUT = 1'b0;
   logic MISMATCH, ERR_STICKY, BUSY, DONE;
   logic [CW-1:0] CHECK_COUNT, ERR_COUNT;
   logic [47:0] FIRST_EXP, FIRST_GOT;

   always #5 CLK = ~CLK;

   dsp48a1_result_monitor #(.CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
      .VALID(VALID), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
      .OPMODE(OPMODE), .P_DUT(P_DUT), .CARRYOUT_DUT(CARRYOUT_DUT),
      .MISMATCH(MISMATCH), .ERR_STICKY(ERR_STICKY),
      .CHECK_COUNT(CHECK_COUNT), .ERR_COUNT(ERR_COUNT),
      .FIRST_EXP(FIRST_EXP), .FIRST_GOT(FIRST_GOT),
      .BUSY(BUSY), .DONE(DONE)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [47:0] act,
                      input logic [47:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [17:0] a, b, d;
      logic [47:0] c, pcin;
      logic [7:0]  op;
      logic [47:0] perr;
      logic        coerr;
      int          pe;
   } set_t;

   typedef struct {
      int          due;
      logic [47:0] p;
      logic        co;
      logic [47:0] perr;
      logic        coerr;
   } rec_t;

   rec_t q[$];
   logic [47:0] plog[$];
   set_t dset;
   bit   hdef = 0;
   int   mode = M_IDLE;
   int   dleft = 0;
   int   pe = 0;
   logic [47:0] pmod = '0;
   logic [47:0] labd = '0;
   logic mmis = 1'b0;
   logic msticky = 1'b0;
   logic [CW-1:0] mchk = '0;
   logic [CW-1:0] merr = '0;
   logic [47:0] mfexp = '0;
   logic [47:0] mfgot = '0;
   logic [47:0] perr_in = '0;
   logic coerr_in = 1'b0;

   // DSP result for one operand set, straight from the datasheet formulas
   function automatic rec_t evaluate(input set_t s, input logic [47:0] abd,
                                     input logic [47:0] pprev);
      rec_t r;
      logic [17:0] pr, bs;
      logic [35:0] m;
      logic [47:0] x, z;
      logic [48:0] t;
      pr = s.op[6] ? s.d - s.b : s.d + s.b;
      bs = s.op[4] ? pr : s.b;
      m = 36'(s.a) * 36'(bs);
      case (s.op[1:0])
         2'd0: x = '0;
         2'd1: x = 48'(m);
         2'd2: x = pprev;
         default: x = abd;
      endcase
      case (s.op[3:2])
         2'd0: z = '0;
         2'd1: z = s.pcin;
         2'd2: z = pprev;
         default: z = s.c;
      endcase
      if (s.op[7]) t = 49'(z) - 49'(x) - 49'(s.op[5]);
      else t = 49'(z) + 49'(x) + 49'(s.op[5]);
      r.due = 0;
      r.p = t[47:0];
      r.co = t[48];
      r.perr = s.perr;
      r.coerr = s.coerr;
      return r;
   endfunction

   // model update per clock, then DSP drive and output compare
   always @(posedge CLK) begin
      rec_t r;
      logic fail, acc;
      logic [47:0] got;
      int pm_;
      pe++;
      mmis = 1'b0;
      if (!RST_N) begin
         mode = M_IDLE;
         dleft = 0;
         pmod = '0;
         labd = '0;
         hdef = 0;
         q.delete();
         msticky = 1'b0;
         mchk = '0;
         merr = '0;
         mfexp = '0;
         mfgot = '0;
      end else begin
         pm_ = mode;
         if (q.size() > 0 && q[0].due == pe) begin
            r = q.pop_front();
            if (pm_ == M_RUN || pm_ == M_DRAIN) begin
               got = r.p ^ r.perr;
               fail = (got != r.p);
`ifdef DSP_MON_CARRYOUT_CHK_EN
               fail = fail || r.coerr;
`endif
               if (mchk != CMAX) mchk++;
               if (fail) begin
                  mmis = 1'b1;
                  if (merr != CMAX) merr++;
                  if (!msticky) begin
                     mfexp = r.p;
                     mfgot = got;
                  end
                  msticky = 1'b1;
               end
            end
         end
         acc = (pm_ == M_RUN) && VALID;
         if (acc) labd = {D[11:0], A, B};
         if (hdef) begin
            r = evaluate(dset, labd, pmod);
            r.due = dset.pe + 3;
            pmod = r.p;
            plog.push_back(r.p);
            q.push_back(r);
            hdef = 0;
         end
         if (acc) begin
            dset.a = A;
            dset.b = B;
            dset.d = D;
            dset.c = C;
            dset.pcin = PCIN;
            dset.op = OPMODE;
            dset.perr = perr_in;
            dset.coerr = coerr_in;
            dset.pe = pe;
            hdef = 1;
         end
         case (pm_)
            M_IDLE: if (START) mode = M_RUN;
            M_RUN: if (STOP) begin
               mode = M_DRAIN;
               dleft = 3;
            end
            M_DRAIN: begin
               dleft--;
               if (dleft == 0) mode = M_DONE;
            end
            default: if (START) mode = M_RUN;
         endcase
         if (mode == M_RUN && pm_ != M_RUN) begin
            msticky = 1'b0;
            mchk = '0;
            merr = '0;
            mfexp = '0;
            mfgot = '0;
            q.delete();
            hdef = 0;
         end
      end
      #1;
      if (q.size() > 0 && q[0].due == pe + 1) begin
         P_DUT = q[0].p ^ q[0].perr;
         CARRYOUT_DUT = q[0].co ^ q[0].coerr;
      end
      chk("mismatch", 48'(MISMATCH), 48'(mmis));
      chk("sticky", 48'(ERR_STICKY), 48'(msticky));
      chk("check_count", 48'(CHECK_COUNT), 48'(mchk));
      chk("err_count", 48'(ERR_COUNT), 48'(merr));
      chk("first_exp", FIRST_EXP, mfexp);
      chk("first_got", FIRST_GOT, mfgot);
      chk("busy", 48'(BUSY), 48'(mode == M_RUN || mode == M_DRAIN));
      chk("done", 48'(DONE), 48'(mode == M_DONE));
   end

   task automatic idle(input int n);
      VALID = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic start_run();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic issue(input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] d, input logic [47:0] c,
                        input logic [47:0] pc, input logic [7:0] op,
                        input logic [47:0] pe_, input logic ce);
      VALID = 1'b1;
      A = a;
      B = b;
      D = d;
      C = c;
      PCIN = pc;
      OPMODE = op;
      perr_in = pe_;
      coerr_in = ce;
      @(negedge CLK);
      VALID = 1'b0;
      START = 1'b0;
      STOP = 1'b0;
      perr_in = '0;
      coerr_in = 1'b0;
   endtask

   initial begin
      int base;
      repeat (2) @(negedge CLK);
      chk("rst_check_count", 48'(CHECK_COUNT), 48'd0);
      chk("rst_busy", 48'(BUSY), 48'd0);
      chk("rst_first_exp", FIRST_EXP, 48'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      start_run();
      chk("run_busy", 48'(BUSY), 48'd1);

      issue(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 8'b00011101, 48'd0, 1'b0);
      idle(5);
      chk("t1_model_p", plog[0], 48'h14);
      chk("t1_check_count", 48'(CHECK_COUNT), 48'd1);
      chk("t1_err_count", 48'(ERR_COUNT), 48'd0);

      issue(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 8'b00011101, 48'h1, 1'b0);
      idle(5);
      chk("t2_sticky", 48'(ERR_STICKY), 48'd1);
      chk("t2_first_exp", FIRST_EXP, 48'h14);
      chk("t2_first_got", FIRST_GOT, 48'h15);

      issue(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 8'b00011101, 48'h100, 1'b0);
      idle(5);
      chk("t3_first_got_kept", FIRST_GOT, 48'h15);
      chk("t3_err_count", 48'(ERR_COUNT), 48'd2);

      issue(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'b10001100, 48'd0, 1'b1);
      idle(5);
      chk("t4_model_p", plog[3], 48'd0);
      chk("t4_err_count", 48'(ERR_COUNT), 48'(2 + COE));

      issue(18'd6, 18'd3, 18'd10, 48'd0, 48'd0, 8'b01010001, 48'd0, 1'b0);
      issue(18'd2, 18'd1, 18'd0, 48'd0, 48'd0, 8'b01010001, 48'd0, 1'b0);
      issue(18'd3, 18'd4, 18'd0, 48'd0, 48'd100, 8'b00000101, 48'd0, 1'b0);
      issue(18'd3, 18'd4, 18'd0, 48'd0, 48'd0, 8'b10000001, 48'd0, 1'b0);
      idle(1);
      issue(18'd1, 18'd2, 18'h123, 48'd0, 48'd0, 8'b00000011, 48'd0, 1'b0);
      idle(5);
      chk("t5_presub", plog[4], 48'h2a);
      chk("t5_prewrap", plog[5], 48'h7fffe);
      chk("t5_pcin", plog[6], 48'h70);
      chk("t5_borrow", plog[7], 48'hfffffffffff4);
      chk("t5_concat", plog[8], 48'h123000040002);
      chk("t5_check_count", 48'(CHECK_COUNT), 48'd9);

      start_run();
      chk("t6_start_ignored", 48'(CHECK_COUNT), 48'd9);

      STOP = 1'b1;
      issue(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 8'b00011101, 48'h1, 1'b0);
      idle(5);
      chk("t7_done", 48'(DONE), 48'd1);
      chk("t7_check_count", 48'(CHECK_COUNT), 48'd10);
      chk("t7_err_count", 48'(ERR_COUNT), 48'(3 + COE));

      start_run();
      chk("t8_cleared", 48'(CHECK_COUNT), 48'd0);
      chk("t8_sticky", 48'(ERR_STICKY), 48'd0);
      START = 1'b1;
      STOP = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      STOP = 1'b0;
      idle(4);
      chk("t9_stop_wins", 48'(DONE), 48'd1);

      RST_N = 1'b0;
      idle(2);
      RST_N = 1'b1;
      idle(1);
      start_run();
      base = plog.size();
      repeat (5)
         issue(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'b00101000, 48'd0, 1'b0);
      idle(5);
      for (int i = 0; i < 5; i++)
         chk("t10_accum", plog[base + i], 48'(i + 1));
      chk("t10_err_count", 48'(ERR_COUNT), 48'd0);
      chk("t10_check_count", 48'(CHECK_COUNT), 48'd5);

      STOP = 1'b1;
      @(negedge CLK);
      STOP = 1'b0;
      idle(4);
      start_run();
      repeat (19)
         issue(18'd1, 18'd1, 18'd0, 48'd0, 48'd0, 8'b00000001, 48'h1, 1'b0);
      idle(5);
      chk("t11_err_sat", 48'(ERR_COUNT), 48'(CMAX));
      chk("t11_chk_sat", 48'(CHECK_COUNT), 48'(CMAX));

      STOP = 1'b1;
      issue(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 8'b00011101, 48'h1, 1'b0);
      RST_N = 1'b0;
      idle(3);
      chk("t12_rst_busy", 48'(BUSY), 48'd0);
      chk("t12_rst_err", 48'(ERR_COUNT), 48'd0);
      chk("t12_rst_sticky", 48'(ERR_STICKY), 48'd0);
      RST_N = 1'b1;
      idle(6);
      chk("t12_no_mismatch", 48'(MISMATCH), 48'd0);
      chk("t12_check_count", 48'(CHECK_COUNT), 48'd0);
      chk("t12_done", 48'(DONE), 48'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
